// File: rtl/keypoint_reader.sv
// Streams the keypoint lists from the two DoG keypoint SRAMs, layer 1 then layer 2,
// through a 2-entry output buffer to the orientation/descriptor stage.
module keypoint_reader #(
    parameter int DEPTH      = 2048,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] count_1,
    input  logic [11:0] count_2,
    output logic [10:0] keypoint_1_addr,
    input  logic [18:0] keypoint_1_dout,
    output logic [10:0] keypoint_2_addr,
    input  logic [18:0] keypoint_2_dout,
    output logic        kp_valid,
    input  logic        kp_ready,
    output logic [8:0]  kp_row,
    output logic [9:0]  kp_col,
    output logic        kp_layer,
    output logic        kp_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ_1, ST_READ_2, ST_DRAIN} state_t;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic       layer;
        logic       last;
    } kp_entry_t;

    localparam logic [2:0]  FIFO_LIMIT = 3'(FIFO_DEPTH);
    localparam logic [11:0] MAX_COUNT  = 12'(DEPTH);

    function automatic logic [11:0] saturate(input logic [11:0] c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

    state_t      state, state_nxt;
    logic [11:0] cnt_1, cnt_2, rd_cnt;
    logic [10:0] addr_1, addr_2;
    logic        inflight, infl_layer, infl_last;
    kp_entry_t   fifo_mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  fifo_count;
    logic        done_q;

    logic [11:0] sat_1, sat_2, cur_cnt;
    logic [2:0]  occupancy;
    logic        start_ok, pop, reading, issue, final_of_layer, final_overall;
    logic [18:0] push_data;
    kp_entry_t   head, push_entry;

    assign sat_1     = saturate(count_1);
    assign sat_2     = saturate(count_2);
    assign start_ok  = start && (state == ST_IDLE);
    assign head      = fifo_mem[rd_ptr];
    assign kp_valid  = (fifo_count != 2'd0);
    assign pop       = kp_valid && kp_ready;
    assign reading   = (state == ST_READ_1) || (state == ST_READ_2);
    // A pop this cycle frees a slot, so reads keep flowing at full rate under kp_ready=1.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = reading && (occupancy < FIFO_LIMIT);
    assign cur_cnt   = (state == ST_READ_2) ? cnt_2 : cnt_1;
    assign final_of_layer = (rd_cnt == cur_cnt - 12'd1);
    assign final_overall  = final_of_layer && ((state == ST_READ_2) || (cnt_2 == 12'd0));

    assign push_data  = infl_layer ? keypoint_2_dout : keypoint_1_dout;
    assign push_entry = '{row: push_data[18:10], col: push_data[9:0],
                          layer: infl_layer, last: infl_last};

    // NOTE: every signal driven here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (sat_1 != 12'd0)      state_nxt = ST_READ_1;
                    else if (sat_2 != 12'd0) state_nxt = ST_READ_2;
                    else                     state_nxt = ST_DRAIN;
                end
            end
            ST_READ_1: begin
                if (issue && final_of_layer)
                    state_nxt = (cnt_2 != 12'd0) ? ST_READ_2 : ST_DRAIN;
            end
            ST_READ_2: begin
                if (issue && final_of_layer) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_count == 2'd0 && !inflight) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt_1      <= '0;
            cnt_2      <= '0;
            rd_cnt     <= '0;
            addr_1     <= '0;
            addr_2     <= '0;
            inflight   <= 1'b0;
            infl_layer <= 1'b0;
            infl_last  <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
            done_q     <= 1'b0;
            // NOTE: the buffer entries are reset too because kp_row/kp_col come straight from the head entry and must read 0 after reset.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            done_q   <= (start_ok && sat_1 == 12'd0 && sat_2 == 12'd0) || (pop && head.last);
            inflight <= issue;
            infl_layer <= (state == ST_READ_2);
            infl_last  <= issue && final_overall;

            if (start_ok) begin
                cnt_1  <= sat_1;
                cnt_2  <= sat_2;
                rd_cnt <= '0;
                addr_1 <= '0;
                addr_2 <= '0;
            end else if (issue) begin
                rd_cnt <= final_of_layer ? 12'd0 : rd_cnt + 12'd1;
                if (state == ST_READ_1) addr_1 <= addr_1 + 11'd1;
                else                    addr_2 <= addr_2 + 11'd1;
            end

            if (inflight) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= 2'(fifo_count + {1'b0, inflight} - {1'b0, pop});
        end
    end

    assign keypoint_1_addr = addr_1;
    assign keypoint_2_addr = addr_2;
    assign kp_row   = head.row;
    assign kp_col   = head.col;
    assign kp_layer = head.layer;
    assign kp_last  = head.last;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_keypoint_reader.sv
// Bench for keypoint_reader: SRAM models with known contents, a scoreboard of expected
// keypoints, and a negedge monitor that checks every handshake and stall stability.
module tb_keypoint_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] count_1 = '0, count_2 = '0;
    logic [10:0] keypoint_1_addr, keypoint_2_addr;
    logic [18:0] keypoint_1_dout = '0, keypoint_2_dout = '0;
    logic        kp_valid, kp_ready = 1'b1;
    logic [8:0]  kp_row;
    logic [9:0]  kp_col;
    logic        kp_layer, kp_last, busy, done;

    keypoint_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count_1(count_1), .count_2(count_2),
        .keypoint_1_addr(keypoint_1_addr), .keypoint_1_dout(keypoint_1_dout),
        .keypoint_2_addr(keypoint_2_addr), .keypoint_2_dout(keypoint_2_dout),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_row(kp_row), .kp_col(kp_col),
        .kp_layer(kp_layer), .kp_last(kp_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [18:0] mem1 [2048];
    logic [18:0] mem2 [2048];

    // Registered-read SRAMs: data follows the address by one cycle.
    always @(posedge clk) begin
        keypoint_1_dout <= mem1[keypoint_1_addr];
        keypoint_2_dout <= mem2[keypoint_2_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [20:0] sb [$];
    int done_cnt = 0, done_cyc = -1, first_valid_cyc = -1, last_cyc = -1, valid_cycles = 0;
    logic        hold_pending = 1'b0;
    logic [20:0] held;
    int t0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] sat(input logic [11:0] c);
        return (c > 12'd2048) ? 12'd2048 : c;
    endfunction

    // Monitor: compare every accepted keypoint with the scoreboard head, and check stalled outputs hold.
    always @(negedge clk) begin
        logic [20:0] cur;
        logic [20:0] exp;
        cur = {kp_row, kp_col, kp_layer, kp_last};
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) check("hold_stable", 32'(cur), 32'(held));
            if (kp_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (kp_valid && kp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_kp", 32'(cur), 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    check("kp_entry", 32'(cur), 32'(exp));
                end
                if (kp_last) last_cyc = cyc;
            end
            hold_pending = kp_valid && !kp_ready;
            held = cur;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_run(input logic [11:0] c1, input logic [11:0] c2);
        logic [11:0] s1, s2;
        s1 = sat(c1);
        s2 = sat(c2);
        for (int i = 0; i < int'(s1); i++)
            sb.push_back({mem1[i], 1'b0, (i == int'(s1) - 1) && (s2 == 12'd0)});
        for (int i = 0; i < int'(s2); i++)
            sb.push_back({mem2[i], 1'b1, (i == int'(s2) - 1)});
        first_valid_cyc = -1;
        last_cyc = -1;
        valid_cycles = 0;
        @(posedge clk); #1;
        count_1 = c1;
        count_2 = c2;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready held; mode 1: ready toggles every cycle.
    task automatic wait_done(input string name, input int budget, input int mode);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (mode == 1) kp_ready = ~kp_ready;
        end
        check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        kp_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 19'(i * 37 + 5);
            mem2[i] = 19'(i * 53 + 300000);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        check("rst_valid", 32'(kp_valid), 32'd0);
        check("rst_fields", 32'({kp_row, kp_col, kp_layer, kp_last}), 32'd0);
        check("rst_addrs", 32'({keypoint_1_addr, keypoint_2_addr}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("sram1_word0", 32'(mem1[0]), 32'd5);
        check("sram2_word1", 32'(mem2[1]), 32'd300053);

        // Test 1: 3 + 2, ready held high.
        start_run(12'd3, 12'd2);
        wait_done("t1", 40, 0);
        check("t1_first_valid_c3", 32'(first_valid_cyc - t0), 32'd3);
        check("t1_last_c7", 32'(last_cyc - t0), 32'd7);
        check("t1_done_c8", 32'(done_cyc - t0), 32'd8);
        check("t1_busy_low_c9", 32'({busy, 32'(cyc - t0) == 32'd9}), 32'b01);

        // Test 2: both counts zero.
        start_run(12'd0, 12'd0);
        wait_done("t2", 10, 0);
        check("t2_done_c1", 32'(done_cyc - t0), 32'd1);
        check("t2_no_valid", 32'(valid_cycles), 32'd0);
        check("t2_addrs_zero", 32'({keypoint_1_addr, keypoint_2_addr}), 32'd0);

        // Test 3: 4 + 0 with ready toggling.
        repeat (3) @(posedge clk);
        start_run(12'd4, 12'd0);
        wait_done("t3", 60, 1);
        check("t3_addr2_zero", 32'(keypoint_2_addr), 32'd0);

        // Test 4: 5 + 0 with a long stall before any acceptance.
        repeat (3) @(posedge clk);
        #1 kp_ready = 1'b0;
        start_run(12'd5, 12'd0);
        repeat (9) begin @(posedge clk); #1; end
        check("t4_valid_held", 32'(kp_valid), 32'd1);
        check("t4_head_sram1_0", 32'({kp_row, kp_col}), 32'd5);
        check("t4_two_reads", 32'(keypoint_1_addr), 32'd2);
        kp_ready = 1'b1;
        wait_done("t4", 40, 0);

        // Test 5: saturating count_1, single layer-2 keypoint.
        repeat (3) @(posedge clk);
        start_run(12'd4000, 12'd1);
        wait_done("t5", 2200, 0);
        check("t5_last_cycle", 32'(last_cyc - t0), 32'd2051);

        // Test 6: reset during layer-2 reads, then a short run.
        repeat (3) @(posedge clk);
        start_run(12'd2, 12'd5);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t6_rst_outputs", 32'({kp_valid, kp_row, kp_col, kp_layer, kp_last, busy, done}), 32'd0);
        check("t6_rst_addrs", 32'({keypoint_1_addr, keypoint_2_addr}), 32'd0);
        begin
            int d0;
            d0 = done_cnt;
            repeat (8) begin @(posedge clk); #1; end
            check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        end
        start_run(12'd1, 12'd0);
        wait_done("t6", 20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
